// File: rtl/tachyon_timeline_sim_if.sv
// tachyon_timeline_sim_if: schematic character beat stream with valid/ready.
interface tachyon_timeline_sim_if;
  logic beam_empty;
  logic beam_enter;
  logic beam_splitter;
  logic beam_line_feed;
  logic beam_eof;
  logic beam_in_valid;
  logic beam_in_ready;
  modport master (
    output beam_empty, beam_enter, beam_splitter, beam_line_feed, beam_eof, beam_in_valid,
    input  beam_in_ready
  );
  modport slave (
    input  beam_empty, beam_enter, beam_splitter, beam_line_feed, beam_eof, beam_in_valid,
    output beam_in_ready
  );
endinterface

// File: rtl/tachyon_timeline_sim.sv
// tachyon_timeline_sim: full-grid tachyon manifold simulator counting splits and distinct timelines.
module tachyon_timeline_sim #(
  parameter int MAX_WIDTH   = 141,
  parameter int COUNT_WIDTH = 48,
  parameter int SPLIT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  tachyon_timeline_sim_if.slave  beam,
  output logic [SPLIT_WIDTH-1:0] split_count,
  output logic [COUNT_WIDTH-1:0] timeline_count,
  output logic                   result_valid,
  output logic                   overflow,
  output logic                   format_error
);
  localparam int XW = $clog2(MAX_WIDTH + 1);
  localparam int IW = $clog2(MAX_WIDTH);
  localparam int CW = COUNT_WIDTH;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, SCAN, SUM, DONE} state_t;
  state_t state, state_nx;
  cnt_t cur [MAX_WIDTH];
  cnt_t nxt [MAX_WIDTH];
  cnt_t acc, cx;
  logic [XW-1:0] x, width;
  logic [IW-1:0] xc, xl, xr;
  logic first_line;
  logic [SPLIT_WIDTH-1:0] split_int;
  logic accept, is_eof, is_lf, is_ch, in_range, ch_ok, swap, split_hit, do_l, do_r, last_col, ov_scan, fe_new;
  logic [CW:0] e1, ctr, lft, rgt, s;
  // Top bit flags saturation; the low bits already hold the clamped sum.
  function automatic logic [CW:0] sat_add(input cnt_t a, input cnt_t b);
    logic [CW:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[CW] ? {1'b1, {CW{1'b1}}} : t;
  endfunction
  assign beam.beam_in_ready = (state == IDLE) || (state == SCAN);
  assign accept    = beam.beam_in_valid & beam.beam_in_ready;
  assign is_eof    = beam.beam_eof;
  assign is_lf     = ~beam.beam_eof & beam.beam_line_feed;
  assign is_ch     = ~beam.beam_eof & ~beam.beam_line_feed;
  assign in_range  = x < XW'(MAX_WIDTH);
  assign ch_ok     = accept & is_ch & in_range;
  assign swap      = accept & (is_lf | is_eof) & (x != '0);
  assign last_col  = x == XW'(MAX_WIDTH - 1);
  assign xc        = in_range ? IW'(x) : '0;
  assign xl        = (xc == '0) ? xc : xc - 1'b1;
  assign xr        = (xc == IW'(MAX_WIDTH - 1)) ? xc : xc + 1'b1;
  assign cx        = cur[xc];
  assign split_hit = beam.beam_splitter & ~beam.beam_enter & (cx != '0);
  assign do_l      = split_hit & (x != '0);
  assign do_r      = split_hit & (({1'b0, x} + 1'b1) < {1'b0, width});
  assign e1        = sat_add(cx, cnt_t'(1));
  assign ctr       = sat_add(nxt[xc], beam.beam_enter ? e1[CW-1:0] : cx);
  assign lft       = sat_add(nxt[xl], cx);
  assign rgt       = sat_add(nxt[xr], cx);
  assign s         = sat_add(acc, cx);
  assign ov_scan   = ch_ok & (split_hit ? ((do_l & lft[CW]) | (do_r & rgt[CW]) | (&split_int))
                                        : (ctr[CW] | (beam.beam_enter & e1[CW])));
  assign fe_new    = accept & ((is_ch & ~in_range) | (is_eof & (x != '0)) |
                               (swap & ~first_line & (x != width)));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, SCAN: state_nx = accept ? (is_eof ? SUM : SCAN) : state;
      SUM:        state_nx = last_col ? DONE : SUM;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_WIDTH; i++) begin
        cur[i] <= '0;
        nxt[i] <= '0;
      end
      x              <= '0;
      width          <= '0;
      first_line     <= 1'b1;
      split_int      <= '0;
      acc            <= '0;
      split_count    <= '0;
      timeline_count <= '0;
      result_valid   <= 1'b0;
      overflow       <= 1'b0;
      format_error   <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      // The first beat of a grid drops the previous grid's sticky flags.
      if (accept) begin
        overflow     <= ((state == SCAN) & overflow) | ov_scan;
        format_error <= ((state == SCAN) & format_error) | fe_new;
      end
      if (ch_ok) begin
        if (split_hit) begin
          if (do_l) nxt[xl] <= lft[CW-1:0];
          if (do_r) nxt[xr] <= rgt[CW-1:0];
          split_int <= split_int + SPLIT_WIDTH'(~&split_int);
        end else nxt[xc] <= ctr[CW-1:0];
        x <= x + 1'b1;
      end
      if (swap) begin
        for (int i = 0; i < MAX_WIDTH; i++) begin
          cur[i] <= nxt[i];
          nxt[i] <= '0;
        end
        x          <= '0;
        first_line <= 1'b0;
        if (first_line) width <= x;
      end
      if (state == SUM) begin
        acc <= s[CW-1:0];
        x   <= x + 1'b1;
        if (s[CW]) overflow <= 1'b1;
        if (last_col) begin
          split_count    <= split_int;
          timeline_count <= s[CW-1:0];
          result_valid   <= 1'b1;
        end
      end
      // Leave IDLE with a blank slate so the next grid's first beat sees cleared state.
      if (state == DONE) begin
        for (int i = 0; i < MAX_WIDTH; i++) begin
          cur[i] <= '0;
          nxt[i] <= '0;
        end
        x          <= '0;
        width      <= '0;
        first_line <= 1'b1;
        split_int  <= '0;
        acc        <= '0;
      end
    end
  end
endmodule
